apb_ucpd_rx_symdec: RTL and testbench
=====================================

// Module: apb_ucpd_rx_symdec
// PURPOSE
//  Receive-side 4b5b symbol decoder for the UCPD core; the inverse of the transmit ordered-set/4b5b encoder.
//  Consumes 5-bit symbols from the BMC receive path after preamble lock and classifies the 4-symbol ordered set.
//  Assembles data nibbles into bytes and detects EOP, flagging invalid symbols, odd-nibble frames and overflow.
//  Byte stream feeds the RX CRC checker and RXDR; ordset and reset detects feed the status/interrupt logic.
// PARAMETERS
//  MAX_BYTES  264  max payload+CRC bytes per frame; the next byte beyond this is an overflow error
//  CNT_W      10   width of rx_byte_cnt
// PORTS
//  ic_clk        in   1      UCPD kernel clock; single clock domain
//  ic_rst        in   1      synchronous reset, active high
//  rx_en         in   1      decoder enable; low forces IDLE and clears all outputs
//  sop_start     in   1      1-cycle pulse: preamble complete, next symbol is K-code 1 of the ordered set
//  sym_vld       in   1      1-cycle strobe: sym holds a new 5b symbol
//  sym           in   5      received symbol in standard 4b5b table bit order
//  ordset_en     in   7      per-type enable: [0]SOP [1]SOP' [2]SOP'' [3]SOP'Dbg [4]SOP''Dbg [5]HRST [6]CRST
//  ordset_vld    out  1      pulse: SOP-class ordered set accepted
//  ordset_type   out  3      accepted type index per ordset_en bit numbering; held until next accept
//  ordset_exact  out  1      accepted with all 4 K-codes correct (0 = 3-of-4 match); held with ordset_type
//  hrst_det      out  1      pulse: Hard Reset ordered set accepted
//  crst_det      out  1      pulse: Cable Reset ordered set accepted
//  byte_vld      out  1      pulse: rx_byte valid
//  rx_byte       out  8      {hi nibble, lo nibble}; lo nibble is received first
//  rx_byte_cnt   out  CNT_W  bytes delivered in current frame; cleared on sop_start
//  eop_vld       out  1      pulse: EOP received on a byte boundary
//  sym_err       out  1      pulse: frame aborted (invalid symbol, odd nibble, overflow, unmatched ordset)
//  busy          out  1      high when state != IDLE
// BEHAVIOUR
//  Reset or rx_en=0: state=IDLE; all pulses 0, ordset_type=0, ordset_exact=0, rx_byte=0, rx_byte_cnt=0, busy=0.
//  Package codes (5'b): data 0..F = 11110,01001,10100,10101,01010,01011,01110,01111,10010,10011,10110,10111,11010,11011,11100,11101.
//  K-codes: SYNC1=11000, SYNC2=10001, SYNC3=00110, RST1=00111, RST2=11001, EOP=01101; all others invalid.
//  Sets (K1..K4): SOP=S1 S1 S1 S2; SOP'=S1 S1 S3 S3; SOP''=S1 S3 S1 S3; SOP'Dbg=S1 R2 R2 S3; SOP''Dbg=S1 R2 S3 S2;
//    HRST=R1 R1 R1 R2; CRST=R1 S1 R1 S3.
//  States: IDLE, ORDSET, DATA_LO, DATA_HI.
//  IDLE: sym_vld ignored; sop_start -> ORDSET, k_idx=0, rx_byte_cnt=0.
//  sop_start in any state restarts ORDSET (resync); if sop_start and sym_vld coincide, sym is dropped.
//  ORDSET: each sym_vld stores sym in slot k_idx, k_idx++; on 4th symbol evaluate in the same clock edge.
//    Match = >=3 of 4 slots equal to the table; enabled types only; lowest index wins on ties; exact beats 3-of-4.
//    Outputs register one cycle after the 4th sym_vld (latency 1).
//    SOP-class match -> ordset_vld=1, ordset_type/exact updated, -> DATA_LO.
//    HRST/CRST match -> hrst_det/crst_det=1, ordset_type/exact updated, -> IDLE.
//    No enabled match -> sym_err=1 -> IDLE.
//  DATA_LO: data sym -> lo nibble latched, -> DATA_HI; EOP -> eop_vld=1 -> IDLE; other -> sym_err=1 -> IDLE.
//  DATA_HI: data sym -> byte_vld=1, rx_byte={nib,lo}, rx_byte_cnt++ -> DATA_LO; EOP or other -> sym_err=1 -> IDLE.
//  Overflow: a byte completing when rx_byte_cnt==MAX_BYTES -> no byte_vld, sym_err=1 -> IDLE; cnt held at MAX_BYTES.
//  All pulse outputs are registered and last exactly one ic_clk; at most one of them fires per cycle.
//  rx_byte and rx_byte_cnt hold between events; rx_byte_cnt is cleared only by sop_start, reset or rx_en=0.
// STRUCTURE
//  Shared package apb_ucpd_pkg: 5b K-code and data localparams, ordset type indices, 7x20-bit ordset table.
//  Single submodule apb_ucpd_4b5b_dec: combinational sym -> {is_data, nibble[3:0], is_kcode, kcode_id}.
//  Top holds FSM, K-code slots, 3-of-4 matcher (per-type popcount over 4 compares), nibble latch, byte counter.
// TESTING
//  T1 sop_start; S1 S1 S1 S2; data 1,0,F,A; EOP -> ordset_vld type=0 exact=1; bytes 0x01,0xAF; cnt=2; eop_vld.
//  T2 sop_start; S1 S1 R1 S2 with ordset_en=7'h7F -> ordset_vld type=0 exact=0, one cycle after 4th sym.
//  T3 sop_start; R1 R1 R1 R2 -> hrst_det one pulse, busy=0 next cycle; same with ordset_en[5]=0 -> sym_err only.
//  T4 SOP then data 3, then sym 5'b00000 -> sym_err, no byte_vld; then data 3,EOP with odd nibble -> sym_err, no eop_vld.
//  T5 SOP + 265 data bytes -> 264 byte_vld, cnt=264, sym_err on byte 265; sop_start then restarts at cnt=0.
//  T6 rx_en drop mid-DATA_HI and ic_rst mid-ORDSET -> IDLE, all outputs at reset values next cycle.

Source files
------------

// File: rtl/apb_ucpd_pkg.sv
// Shared constants for the UCPD receive path: 4b5b codes, K-code ids,
// ordered-set type indices and the ordered-set K-code table.
package apb_ucpd_pkg;

    // 4b5b data codes, index = nibble value
    localparam logic [15:0][4:0] DATA_TABLE = {
        5'b11101, 5'b11100, 5'b11011, 5'b11010, 5'b10111, 5'b10110, 5'b10011, 5'b10010,
        5'b01111, 5'b01110, 5'b01011, 5'b01010, 5'b10101, 5'b10100, 5'b01001, 5'b11110
    };

    // K-codes
    localparam logic [4:0] K_SYNC1 = 5'b11000;
    localparam logic [4:0] K_SYNC2 = 5'b10001;
    localparam logic [4:0] K_SYNC3 = 5'b00110;
    localparam logic [4:0] K_RST1  = 5'b00111;
    localparam logic [4:0] K_RST2  = 5'b11001;
    localparam logic [4:0] K_EOP   = 5'b01101;

    // K-code ids reported by the symbol decoder
    localparam logic [2:0] KID_S1   = 3'd0;
    localparam logic [2:0] KID_S2   = 3'd1;
    localparam logic [2:0] KID_S3   = 3'd2;
    localparam logic [2:0] KID_R1   = 3'd3;
    localparam logic [2:0] KID_R2   = 3'd4;
    localparam logic [2:0] KID_EOP  = 3'd5;
    localparam logic [2:0] KID_NONE = 3'd7;

    // Ordered-set type indices, matching the ordset_en bit numbering
    localparam int         NUM_OS  = 7;
    localparam logic [2:0] OS_SOP  = 3'd0;
    localparam logic [2:0] OS_HRST = 3'd5;
    localparam logic [2:0] OS_CRST = 3'd6;

    // Each entry is {K1, K2, K3, K4}; K1 is received first
    localparam logic [NUM_OS-1:0][19:0] OS_TABLE = {
        {K_RST1,  K_SYNC1, K_RST1,  K_SYNC3},   // 6 Cable Reset
        {K_RST1,  K_RST1,  K_RST1,  K_RST2 },   // 5 Hard Reset
        {K_SYNC1, K_RST2,  K_SYNC3, K_SYNC2},   // 4 SOP''_Debug
        {K_SYNC1, K_RST2,  K_RST2,  K_SYNC3},   // 3 SOP'_Debug
        {K_SYNC1, K_SYNC3, K_SYNC1, K_SYNC3},   // 2 SOP''
        {K_SYNC1, K_SYNC1, K_SYNC3, K_SYNC3},   // 1 SOP'
        {K_SYNC1, K_SYNC1, K_SYNC1, K_SYNC2}    // 0 SOP
    };

    typedef enum logic [1:0] {StIdle, StOrdset, StDataLo, StDataHi} rx_state_e;

endpackage

// File: rtl/apb_ucpd_4b5b_dec.sv
// Combinational 5b symbol classifier: data nibble or K-code id.
module apb_ucpd_4b5b_dec
    import apb_ucpd_pkg::*;
(
    input  logic [4:0] sym,
    output logic       is_data,
    output logic [3:0] nibble,
    output logic       is_kcode,
    output logic [2:0] kcode_id
);

    // Table lookup for data codes, explicit decode for K-codes
    always_comb begin
        is_data  = 1'b0;
        nibble   = 4'h0;
        is_kcode = 1'b1;
        kcode_id = KID_NONE;
        for (int i = 0; i < 16; i++) begin
            if (sym == DATA_TABLE[i]) begin
                is_data = 1'b1;
                nibble  = i[3:0];
            end
        end
        case (sym)
            K_SYNC1: kcode_id = KID_S1;
            K_SYNC2: kcode_id = KID_S2;
            K_SYNC3: kcode_id = KID_S3;
            K_RST1:  kcode_id = KID_R1;
            K_RST2:  kcode_id = KID_R2;
            K_EOP:   kcode_id = KID_EOP;
            default: is_kcode = 1'b0;
        endcase
    end

endmodule

// File: rtl/apb_ucpd_rx_symdec.sv
// UCPD receive symbol decoder: ordered-set classification, nibble-to-byte
// assembly, EOP detection and frame error flagging.
module apb_ucpd_rx_symdec
    import apb_ucpd_pkg::*;
#(
    parameter int unsigned MAX_BYTES = 264,
    parameter int unsigned CNT_W     = 10
) (
    input  logic             ic_clk,
    input  logic             ic_rst,
    input  logic             rx_en,
    input  logic             sop_start,
    input  logic             sym_vld,
    input  logic [4:0]       sym,
    input  logic [6:0]       ordset_en,
    output logic             ordset_vld,
    output logic [2:0]       ordset_type,
    output logic             ordset_exact,
    output logic             hrst_det,
    output logic             crst_det,
    output logic             byte_vld,
    output logic [7:0]       rx_byte,
    output logic [CNT_W-1:0] rx_byte_cnt,
    output logic             eop_vld,
    output logic             sym_err,
    output logic             busy
);

    rx_state_e        state_q, state_d;
    logic [1:0]       k_idx_q, k_idx_d;
    logic [2:0][4:0]  slot_q, slot_d;
    logic [3:0]       lo_q, lo_d;
    logic [2:0]       type_q, type_d;
    logic             exact_q, exact_d;
    logic [7:0]       byte_q, byte_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             os_vld_q, os_vld_d, hrst_q, hrst_d, crst_q, crst_d;
    logic             bvld_q, bvld_d, eop_q, eop_d, err_q, err_d;

    logic             is_data, is_kcode;
    logic [3:0]       nibble;
    logic [2:0]       kcode_id;
    logic             is_eop;

    apb_ucpd_4b5b_dec u_dec (
        .sym      (sym),
        .is_data  (is_data),
        .nibble   (nibble),
        .is_kcode (is_kcode),
        .kcode_id (kcode_id)
    );

    assign is_eop = is_kcode && (kcode_id == KID_EOP);

    // 3-of-4 matcher; the 4th K-code is taken straight from the input symbol
    logic [19:0]             os_word;
    logic [NUM_OS-1:0][2:0]  hits;
    logic                    m_any, m_exact;
    logic [2:0]              m_type;

    assign os_word = {slot_q[0], slot_q[1], slot_q[2], sym};

    // Per-type hit count, then exact-first / lowest-index-first selection
    always_comb begin
        m_any   = 1'b0;
        m_exact = 1'b0;
        m_type  = 3'd0;
        for (int t = 0; t < NUM_OS; t++) begin
            hits[t] = 3'(os_word[19:15] == OS_TABLE[t][19:15])
                    + 3'(os_word[14:10] == OS_TABLE[t][14:10])
                    + 3'(os_word[9:5]   == OS_TABLE[t][9:5])
                    + 3'(os_word[4:0]   == OS_TABLE[t][4:0]);
        end
        // Descending scan so the lowest enabled index is the one left standing
        for (int t = NUM_OS - 1; t >= 0; t--) begin
            if (ordset_en[t] && hits[t] == 3'd4) begin
                m_exact = 1'b1;
                m_type  = t[2:0];
            end
        end
        if (!m_exact) begin
            for (int t = NUM_OS - 1; t >= 0; t--) begin
                if (ordset_en[t] && hits[t] >= 3'd3) begin
                    m_any  = 1'b1;
                    m_type = t[2:0];
                end
            end
        end
        m_any = m_any | m_exact;
    end

    // Next-state and registered-output computation
    always_comb begin
        state_d  = state_q;
        k_idx_d  = k_idx_q;
        slot_d   = slot_q;
        lo_d     = lo_q;
        type_d   = type_q;
        exact_d  = exact_q;
        byte_d   = byte_q;
        cnt_d    = cnt_q;
        os_vld_d = 1'b0;
        hrst_d   = 1'b0;
        crst_d   = 1'b0;
        bvld_d   = 1'b0;
        eop_d    = 1'b0;
        err_d    = 1'b0;
        if (sop_start) begin
            // Resync from any state; a coincident symbol is dropped
            state_d = StOrdset;
            k_idx_d = 2'd0;
            cnt_d   = '0;
        end else if (sym_vld) begin
            case (state_q)
                StOrdset: begin
                    if (k_idx_q != 2'd3) begin
                        slot_d[k_idx_q] = sym;
                        k_idx_d         = k_idx_q + 2'd1;
                    end else begin
                        k_idx_d = 2'd0;
                        if (!m_any) begin
                            err_d   = 1'b1;
                            state_d = StIdle;
                        end else begin
                            type_d  = m_type;
                            exact_d = m_exact;
                            if (m_type == OS_HRST) begin
                                hrst_d  = 1'b1;
                                state_d = StIdle;
                            end else if (m_type == OS_CRST) begin
                                crst_d  = 1'b1;
                                state_d = StIdle;
                            end else begin
                                os_vld_d = 1'b1;
                                state_d  = StDataLo;
                            end
                        end
                    end
                end
                StDataLo: begin
                    if (is_data) begin
                        lo_d    = nibble;
                        state_d = StDataHi;
                    end else if (is_eop) begin
                        eop_d   = 1'b1;
                        state_d = StIdle;
                    end else begin
                        err_d   = 1'b1;
                        state_d = StIdle;
                    end
                end
                StDataHi: begin
                    if (is_data && cnt_q != CNT_W'(MAX_BYTES)) begin
                        bvld_d  = 1'b1;
                        byte_d  = {nibble, lo_q};
                        cnt_d   = cnt_q + CNT_W'(1);
                        state_d = StDataLo;
                    end else begin
                        // Odd nibble at EOP, bad symbol, or byte beyond MAX_BYTES
                        err_d   = 1'b1;
                        state_d = StIdle;
                    end
                end
                default: ;
            endcase
        end
    end

    // State register; rx_en low behaves like reset
    always_ff @(posedge ic_clk) begin
        if (ic_rst || !rx_en) begin
            state_q  <= StIdle;
            k_idx_q  <= 2'd0;
            slot_q   <= '0;
            lo_q     <= 4'h0;
            type_q   <= 3'd0;
            exact_q  <= 1'b0;
            byte_q   <= 8'h00;
            cnt_q    <= '0;
            os_vld_q <= 1'b0;
            hrst_q   <= 1'b0;
            crst_q   <= 1'b0;
            bvld_q   <= 1'b0;
            eop_q    <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            k_idx_q  <= k_idx_d;
            slot_q   <= slot_d;
            lo_q     <= lo_d;
            type_q   <= type_d;
            exact_q  <= exact_d;
            byte_q   <= byte_d;
            cnt_q    <= cnt_d;
            os_vld_q <= os_vld_d;
            hrst_q   <= hrst_d;
            crst_q   <= crst_d;
            bvld_q   <= bvld_d;
            eop_q    <= eop_d;
            err_q    <= err_d;
        end
    end

    assign ordset_vld   = os_vld_q;
    assign ordset_type  = type_q;
    assign ordset_exact = exact_q;
    assign hrst_det     = hrst_q;
    assign crst_det     = crst_q;
    assign byte_vld     = bvld_q;
    assign rx_byte      = byte_q;
    assign rx_byte_cnt  = cnt_q;
    assign eop_vld      = eop_q;
    assign sym_err      = err_q;
    assign busy         = (state_q != StIdle);

endmodule

// File: tb/tb_apb_ucpd_rx_symdec.sv
// Scoreboard bench for apb_ucpd_rx_symdec: expected pulse events are queued
// as stimulus is driven and compared when the DUT raises any pulse.
module tb_apb_ucpd_rx_symdec;

    localparam logic [4:0] S1  = 5'b11000;
    localparam logic [4:0] S2  = 5'b10001;
    localparam logic [4:0] S3  = 5'b00110;
    localparam logic [4:0] R1  = 5'b00111;
    localparam logic [4:0] R2  = 5'b11001;
    localparam logic [4:0] EOP = 5'b01101;

    // Event kinds
    localparam int EV_OS = 1, EV_HRST = 2, EV_CRST = 3, EV_BYTE = 4, EV_EOP = 5, EV_ERR = 6;

    logic [4:0] dcode [16] = '{5'b11110, 5'b01001, 5'b10100, 5'b10101, 5'b01010, 5'b01011,
                               5'b01110, 5'b01111, 5'b10010, 5'b10011, 5'b10110, 5'b10111,
                               5'b11010, 5'b11011, 5'b11100, 5'b11101};

    logic       ic_clk = 1'b0;
    logic       ic_rst = 1'b1;
    logic       rx_en = 1'b1;
    logic       sop_start = 1'b0;
    logic       sym_vld = 1'b0;
    logic [4:0] sym = 5'd0;
    logic [6:0] ordset_en = 7'h7F;
    logic       ordset_vld, ordset_exact, hrst_det, crst_det, byte_vld, eop_vld, sym_err, busy;
    logic [2:0] ordset_type;
    logic [7:0] rx_byte;
    logic [9:0] rx_byte_cnt;

    int n_vec = 0;
    int n_err = 0;
    logic [31:0] exp_q [$];

    apb_ucpd_rx_symdec #(.MAX_BYTES(264), .CNT_W(10)) dut (
        .ic_clk       (ic_clk),
        .ic_rst       (ic_rst),
        .rx_en        (rx_en),
        .sop_start    (sop_start),
        .sym_vld      (sym_vld),
        .sym          (sym),
        .ordset_en    (ordset_en),
        .ordset_vld   (ordset_vld),
        .ordset_type  (ordset_type),
        .ordset_exact (ordset_exact),
        .hrst_det     (hrst_det),
        .crst_det     (crst_det),
        .byte_vld     (byte_vld),
        .rx_byte      (rx_byte),
        .rx_byte_cnt  (rx_byte_cnt),
        .eop_vld      (eop_vld),
        .sym_err      (sym_err),
        .busy         (busy)
    );

    always #5 ic_clk = ~ic_clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] ev(input int kind, input int payload);
        return {8'(kind), 24'(payload)};
    endfunction

    function automatic string kname(input logic [31:0] e);
        case (int'(e[31:24]))
            EV_OS:   return "ordset";
            EV_HRST: return "hrst";
            EV_CRST: return "crst";
            EV_BYTE: return "byte";
            EV_EOP:  return "eop";
            EV_ERR:  return "sym_err";
            default: return "unknown";
        endcase
    endfunction

    // Monitor: any pulse pops one expected event
    always @(negedge ic_clk) begin
        logic [5:0]  pulses;
        logic [31:0] obs, exp;
        pulses = {ordset_vld, hrst_det, crst_det, byte_vld, eop_vld, sym_err};
        if (pulses != 6'd0) begin
            check("one_pulse", 32'($countones(pulses)), 32'd1);
            if (ordset_vld)     obs = ev(EV_OS,   {ordset_exact, ordset_type});
            else if (hrst_det)  obs = ev(EV_HRST, {ordset_exact, ordset_type});
            else if (crst_det)  obs = ev(EV_CRST, {ordset_exact, ordset_type});
            else if (byte_vld)  obs = ev(EV_BYTE, {rx_byte_cnt, rx_byte});
            else if (eop_vld)   obs = ev(EV_EOP,  0);
            else                obs = ev(EV_ERR,  0);
            if (exp_q.size() == 0) begin
                check({"extra_", kname(obs)}, obs, 32'd0);
            end else begin
                exp = exp_q.pop_front();
                check(kname(exp), obs, exp);
            end
        end
    end

    task automatic tick();
        @(posedge ic_clk);
        #1;
    endtask

    task automatic send_sym(input logic [4:0] s);
        sym = s;
        sym_vld = 1'b1;
        tick();
        sym_vld = 1'b0;
        sym = 5'd0;
    endtask

    task automatic send_gap(input logic [4:0] s);
        send_sym(s);
        if ($urandom_range(0, 1) == 1) tick();
    endtask

    task automatic sop();
        sop_start = 1'b1;
        tick();
        sop_start = 1'b0;
    endtask

    task automatic send_os(input logic [4:0] k1, input logic [4:0] k2,
                           input logic [4:0] k3, input logic [4:0] k4);
        send_sym(k1);
        send_sym(k2);
        send_sym(k3);
        send_sym(k4);
    endtask

    task automatic send_byte(input logic [7:0] b);
        send_gap(dcode[b[3:0]]);
        send_gap(dcode[b[7:4]]);
    endtask

    task automatic check_reset_vals(input string pfx);
        check({pfx, "_busy"},  32'(busy), 32'd0);
        check({pfx, "_type"},  32'(ordset_type), 32'd0);
        check({pfx, "_exact"}, 32'(ordset_exact), 32'd0);
        check({pfx, "_byte"},  32'(rx_byte), 32'd0);
        check({pfx, "_cnt"},   32'(rx_byte_cnt), 32'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) tick();
        ic_rst = 1'b0;
        tick();
        check_reset_vals("reset");

        // T1: SOP with a coincident dropped symbol, two bytes, EOP
        sop_start = 1'b1;
        sym_vld = 1'b1;
        sym = S2;
        tick();
        sop_start = 1'b0;
        sym_vld = 1'b0;
        exp_q.push_back(ev(EV_OS, 8));
        send_os(S1, S1, S1, S2);
        check("t1_busy", 32'(busy), 32'd1);
        exp_q.push_back(ev(EV_BYTE, (1 << 8) | 8'h01));
        exp_q.push_back(ev(EV_BYTE, (2 << 8) | 8'hAF));
        send_gap(dcode[1]);
        send_gap(dcode[0]);
        send_gap(dcode[15]);
        send_gap(dcode[10]);
        exp_q.push_back(ev(EV_EOP, 0));
        send_sym(EOP);
        check("t1_idle", 32'(busy), 32'd0);
        tick();
        check("t1_byte_hold", 32'(rx_byte), 32'hAF);
        check("t1_cnt_hold", 32'(rx_byte_cnt), 32'd2);

        // T2: 3-of-4 SOP, latency one cycle after the 4th symbol
        sop();
        send_sym(S1);
        send_sym(S1);
        send_sym(R1);
        check("t2_no_early", 32'(ordset_vld), 32'd0);
        exp_q.push_back(ev(EV_OS, 0));
        send_sym(S2);
        check("t2_latency", 32'(ordset_vld), 32'd1);
        exp_q.push_back(ev(EV_EOP, 0));
        send_sym(EOP);
        tick();

        // SOP'' exact
        sop();
        exp_q.push_back(ev(EV_OS, 8 | 2));
        send_os(S1, S3, S1, S3);
        exp_q.push_back(ev(EV_EOP, 0));
        send_sym(EOP);
        tick();

        // T3: Hard Reset, then with HRST disabled, then Cable Reset
        sop();
        exp_q.push_back(ev(EV_HRST, 8 | 5));
        send_os(R1, R1, R1, R2);
        check("t3_hrst_busy", 32'(busy), 32'd0);
        check("t3_hrst_type", 32'(ordset_type), 32'd5);
        tick();
        ordset_en = 7'h5F;
        sop();
        exp_q.push_back(ev(EV_ERR, 0));
        send_os(R1, R1, R1, R2);
        tick();
        ordset_en = 7'h7F;
        sop();
        exp_q.push_back(ev(EV_CRST, 8 | 6));
        send_os(R1, S1, R1, S3);
        tick();

        // T4: invalid symbol mid-byte, then odd-nibble EOP
        sop();
        exp_q.push_back(ev(EV_OS, 8));
        send_os(S1, S1, S1, S2);
        send_gap(dcode[3]);
        exp_q.push_back(ev(EV_ERR, 0));
        send_sym(5'b00000);
        check("t4_err_idle", 32'(busy), 32'd0);
        tick();
        sop();
        exp_q.push_back(ev(EV_OS, 8));
        send_os(S1, S1, S1, S2);
        send_gap(dcode[3]);
        exp_q.push_back(ev(EV_ERR, 0));
        send_sym(EOP);
        tick();

        // T5: 265 bytes; the last one overflows
        sop();
        exp_q.push_back(ev(EV_OS, 8));
        send_os(S1, S1, S1, S2);
        for (int i = 0; i < 265; i++) begin
            if (i < 264) exp_q.push_back(ev(EV_BYTE, ((i + 1) << 8) | (i & 8'hFF)));
            else         exp_q.push_back(ev(EV_ERR, 0));
            send_byte(8'(i));
        end
        tick();
        check("t5_cnt_max", 32'(rx_byte_cnt), 32'd264);
        check("t5_last_byte", 32'(rx_byte), 32'h07);
        check("t5_idle", 32'(busy), 32'd0);
        sop();
        check("t5_cnt_clr", 32'(rx_byte_cnt), 32'd0);
        check("t5_restart", 32'(busy), 32'd1);

        // T6: rx_en drop mid-DATA_HI, then reset mid-ORDSET
        sop();
        exp_q.push_back(ev(EV_OS, 8 | 2));
        send_os(S1, S3, S1, S3);
        send_byte(8'h5A);
        exp_q.push_back(ev(EV_BYTE, (1 << 8) | 8'h5A));
        send_sym(dcode[4]);
        rx_en = 1'b0;
        tick();
        check_reset_vals("t6_en");
        rx_en = 1'b1;
        send_sym(dcode[6]);
        tick();
        sop();
        send_sym(S1);
        send_sym(S1);
        ic_rst = 1'b1;
        tick();
        ic_rst = 1'b0;
        check_reset_vals("t6_rst");
        send_os(S1, S1, S1, S2);
        repeat (3) tick();

        check("sb_empty", 32'(exp_q.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
